plot_sink: RTL and testbench

PLOT_SINK -- requirements
Module: plot_sink

---
 rtl/plot_sink.sv | 137 +++++++++++++
 tb/tb_plot_sink.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sink.sv
// Pixel sink between a drawing engine and a single-port framebuffer: queues
// on-screen pixels, writes them out when granted, and performs full-screen fills.
module plot_sink #(
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120,
  parameter int color_depth   = 9,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [7:0]             x,
  input  logic [6:0]             y,
  input  logic [color_depth-1:0] color,
  input  logic                   plot,
  input  logic                   clear_req,
  input  logic [color_depth-1:0] clear_color,
  input  logic                   fb_grant,
  output logic                   ready,
  output logic [14:0]            fb_address,
  output logic [color_depth-1:0] fb_data,
  output logic                   fb_wren,
  output logic                   idle,
  output logic                   clear_done,
  output logic                   overflow,
  output logic [7:0]             clip_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [8:0]       X_LIMIT    = 9'(SCREEN_WIDTH);
  localparam logic [7:0]       Y_LIMIT    = 8'(SCREEN_HEIGHT);
  localparam logic [14:0]      ROW_STRIDE = 15'(SCREEN_WIDTH);
  localparam logic [14:0]      FILL_LAST  = 15'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t                 state, state_next;
  logic [14:0]            addr_mem [FIFO_DEPTH];
  logic [color_depth-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count, count_next;
  logic [14:0]            fill_count, fill_next;
  logic [color_depth-1:0] clear_latch, clear_latch_next;
  logic                   done_next;
  logic                   fifo_empty, fifo_full, in_range;
  logic                   accept, push, clip, pop;
  logic [14:0]            pixel_address;

  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == DEPTH_CNT);
  assign ready         = !fifo_full && (state == IDLE);
  assign idle          = (state == IDLE) && fifo_empty;
  assign in_range      = ({1'b0, x} < X_LIMIT) && ({1'b0, y} < Y_LIMIT);
  assign accept        = plot && ready;
  assign push          = accept && in_range;
  assign clip          = accept && !in_range;
  assign pop           = (state != CLEAR) && !fifo_empty && fb_grant;
  assign pixel_address = {8'd0, y} * ROW_STRIDE + {7'd0, x};
  assign count_next    = count + CNT_W'(push) - CNT_W'(pop);

  // Output mux and next-state: queue head is shown outside CLEAR, zeros when empty.
  always_comb begin
    state_next       = state;
    fill_next        = fill_count;
    clear_latch_next = clear_latch;
    done_next        = 1'b0;
    fb_wren          = 1'b0;
    fb_address       = '0;
    fb_data          = '0;
    case (state)
      IDLE, DRAIN: begin
        if (!fifo_empty) begin
          fb_address = addr_mem[rd_ptr];
          fb_data    = data_mem[rd_ptr];
          fb_wren    = pop;
        end
        if (state == IDLE) begin
          if (clear_req) begin
            clear_latch_next = clear_color;
            state_next       = (count_next != '0) ? DRAIN : CLEAR;
          end
        end else if (count_next == '0) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        fb_address = fill_count;
        fb_data    = clear_latch;
        fb_wren    = fb_grant;
        if (fb_grant) begin
          if (fill_count == FILL_LAST) begin
            state_next = IDLE;
            fill_next  = '0;
            done_next  = 1'b1;
          end else begin
            fill_next = fill_count + 15'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      fill_count  <= '0;
      clear_latch <= '0;
      clear_done  <= 1'b0;
      overflow    <= 1'b0;
      clip_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state       <= state_next;
      fill_count  <= fill_next;
      clear_latch <= clear_latch_next;
      clear_done  <= done_next;
      count       <= count_next;
      if (plot && !ready) overflow <= 1'b1;
      if (clip) clip_count <= clip_count + 8'd1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= pixel_address;
      data_mem[wr_ptr] <= color;
    end
  end

endmodule

// File: tb/tb_plot_sink.sv
// Directed and randomized checks of plot_sink against a queue-based model of
// the pixel path and an address-sequence model of the screen fill.
module tb_plot_sink;

  localparam int W      = 160;
  localparam int H      = 120;
  localparam int PIXELS = W * H;

  logic       clock, resetn;
  logic [7:0] x;
  logic [6:0] y;
  logic [8:0] color, clear_color, fb_data;
  logic       plot, clear_req, fb_grant;
  logic       ready, fb_wren, idle, clear_done, overflow;
  logic [14:0] fb_address;
  logic [7:0] clip_count;

  int total = 0;
  int bad   = 0;
  int qa[$];
  int qd[$];

  plot_sink dut (
    .clock(clock), .resetn(resetn), .x(x), .y(y), .color(color), .plot(plot),
    .clear_req(clear_req), .clear_color(clear_color), .fb_grant(fb_grant),
    .ready(ready), .fb_address(fb_address), .fb_data(fb_data), .fb_wren(fb_wren),
    .idle(idle), .clear_done(clear_done), .overflow(overflow), .clip_count(clip_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    resetn = 1'b0; plot = 1'b0; clear_req = 1'b0; fb_grant = 1'b0;
    qa.delete(); qd.delete();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  // Runs a clear from IDLE: queued pixels (qa/qd) first, then every screen address once.
  task automatic run_clear(input logic [8:0] fill_color, input bit rand_mode);
    int fill_idx = 0;
    int writes = 0;
    int err_seq = 0;
    int err_ready = 0;
    int err_done = 0;
    int err_grant = 0;
    int npre = qa.size();
    @(negedge clock);
    plot = 1'b0; clear_req = 1'b1; clear_color = fill_color;
    fb_grant = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    check_output("clear_start_wren", 32'(fb_wren), 32'(qa.size() > 0 && fb_grant));
    if (fb_wren && qa.size() > 0) begin
      writes++;
      if (int'(fb_address) != qa[0] || int'(fb_data) != qd[0]) err_seq++;
      void'(qa.pop_front()); void'(qd.pop_front());
    end
    for (int cyc = 0; cyc < PIXELS * 3 && fill_idx < PIXELS; cyc++) begin
      @(negedge clock);
      clear_req   = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      clear_color = ~fill_color;
      fb_grant    = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ready) err_ready++;
      if (clear_done) err_done++;
      if (fb_wren) begin
        writes++;
        if (!fb_grant) err_grant++;
        if (qa.size() > 0) begin
          if (int'(fb_address) != qa[0] || int'(fb_data) != qd[0]) err_seq++;
          void'(qa.pop_front()); void'(qd.pop_front());
        end else begin
          if (int'(fb_address) != fill_idx || fb_data !== fill_color) err_seq++;
          fill_idx++;
        end
      end
    end
    check_output("fill_writes", 32'(fill_idx), 32'(PIXELS));
    check_output("total_writes", 32'(writes), 32'(npre + PIXELS));
    check_output("write_sequence_errors", 32'(err_seq), 32'd0);
    check_output("ready_during_clear", 32'(err_ready), 32'd0);
    check_output("early_clear_done", 32'(err_done), 32'd0);
    check_output("wren_without_grant", 32'(err_grant), 32'd0);
    @(negedge clock);
    clear_req = 1'b0; fb_grant = 1'b1;
    #1;
    check_output("clear_done_pulse", 32'(clear_done), 32'd1);
    check_output("ready_after_clear", 32'(ready), 32'd1);
    check_output("idle_after_clear", 32'(idle), 32'd1);
    check_output("wren_after_clear", 32'(fb_wren), 32'd0);
    @(negedge clock);
    #1;
    check_output("clear_done_one_cycle", 32'(clear_done), 32'd0);
  endtask

  initial begin
    bit found;
    int exp_clip;
    bit exp_ovf;
    bit exp_ready, exp_wren;

    resetn = 1'b0; plot = 1'b0; clear_req = 1'b0; fb_grant = 1'b0;
    x = '0; y = '0; color = '0; clear_color = '0;
    #3;
    check_output("rst_ready", 32'(ready), 32'd1);
    check_output("rst_idle", 32'(idle), 32'd1);
    check_output("rst_wren", 32'(fb_wren), 32'd0);
    check_output("rst_addr", 32'(fb_address), 32'd0);
    check_output("rst_data", 32'(fb_data), 32'd0);
    check_output("rst_overflow", 32'(overflow), 32'd0);
    check_output("rst_clip", 32'(clip_count), 32'd0);
    check_output("rst_clear_done", 32'(clear_done), 32'd0);
    @(negedge clock);
    resetn = 1'b1;

    $display("[TB] single plot");
    @(negedge clock);
    plot = 1'b1; x = 8'd3; y = 7'd2; color = 9'h1FF; fb_grant = 1'b1;
    #1;
    check_output("single_ready", 32'(ready), 32'd1);
    check_output("single_wren_before", 32'(fb_wren), 32'd0);
    @(negedge clock);
    plot = 1'b0;
    #1;
    check_output("single_wren", 32'(fb_wren), 32'd1);
    check_output("single_addr", 32'(fb_address), 32'd323);
    check_output("single_data", 32'(fb_data), 32'h1FF);
    check_output("single_busy", 32'(idle), 32'd0);
    @(negedge clock);
    #1;
    check_output("single_idle", 32'(idle), 32'd1);
    check_output("single_wren_after", 32'(fb_wren), 32'd0);

    $display("[TB] queue full and overflow");
    fb_grant = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      plot = 1'b1; x = 8'(10 + k); y = 7'(k); color = 9'(k * 16 + 3);
      #1;
      check_output($sformatf("fill_ready_%0d", k), 32'(ready), 32'(k < 4));
      if (k > 0) begin
        check_output($sformatf("hold_wren_%0d", k), 32'(fb_wren), 32'd0);
        check_output($sformatf("hold_addr_%0d", k), 32'(fb_address), 32'd10);
      end
    end
    @(negedge clock);
    plot = 1'b0;
    #1;
    check_output("overflow_set", 32'(overflow), 32'd1);
    check_output("full_ready", 32'(ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      fb_grant = 1'b1;
      #1;
      check_output($sformatf("drain_wren_%0d", k), 32'(fb_wren), 32'd1);
      check_output($sformatf("drain_addr_%0d", k), 32'(fb_address), 32'(k * W + 10 + k));
      check_output($sformatf("drain_data_%0d", k), 32'(fb_data), 32'(k * 16 + 3));
    end
    @(negedge clock);
    #1;
    check_output("drain_done_idle", 32'(idle), 32'd1);
    check_output("overflow_sticky", 32'(overflow), 32'd1);

    $display("[TB] clipping");
    apply_reset();
    fb_grant = 1'b1;
    @(negedge clock);
    plot = 1'b1; x = 8'd160; y = 7'd0;
    #1;
    check_output("clip_a_wren", 32'(fb_wren), 32'd0);
    @(negedge clock);
    x = 8'd0; y = 7'd120;
    #1;
    check_output("clip_b_wren", 32'(fb_wren), 32'd0);
    @(negedge clock);
    plot = 1'b0;
    #1;
    check_output("clip_c_wren", 32'(fb_wren), 32'd0);
    check_output("clip_count", 32'(clip_count), 32'd2);
    check_output("clip_no_overflow", 32'(overflow), 32'd0);

    $display("[TB] clear after queued pixels");
    fb_grant = 1'b0;
    @(negedge clock);
    plot = 1'b1; x = 8'd5; y = 7'd7; color = 9'h055;
    qa.push_back(7 * W + 5); qd.push_back(9'h055);
    @(negedge clock);
    x = 8'd159; y = 7'd119; color = 9'h1AA;
    qa.push_back(119 * W + 159); qd.push_back(9'h1AA);
    @(negedge clock);
    plot = 1'b0;
    run_clear(9'h0A5, 1'b0);

    $display("[TB] clear with random grant");
    run_clear(9'h13C, 1'b1);

    $display("[TB] reset in the middle of a clear");
    @(negedge clock);
    clear_req = 1'b1; clear_color = 9'h0F0; fb_grant = 1'b1; plot = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 6000 && !found; c++) begin
      @(negedge clock);
      clear_req = 1'b0;
      #1;
      if (fb_wren && fb_address == 15'd5000) found = 1'b1;
    end
    check_output("reached_5000", 32'(found), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("abort_wren", 32'(fb_wren), 32'd0);
    check_output("abort_addr", 32'(fb_address), 32'd0);
    check_output("abort_data", 32'(fb_data), 32'd0);
    check_output("abort_idle", 32'(idle), 32'd1);
    check_output("abort_ready", 32'(ready), 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      #1;
      check_output($sformatf("abort_no_done_%0d", c), 32'(clear_done), 32'd0);
    end

    $display("[TB] randomized pixel traffic");
    apply_reset();
    exp_clip = 0;
    exp_ovf  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      plot     = ($urandom_range(0, 9) < 6);
      x        = 8'($urandom_range(0, 175));
      y        = 7'($urandom_range(0, 127));
      color    = 9'($urandom);
      fb_grant = 1'($urandom_range(0, 1));
      #1;
      exp_ready = (qa.size() < 4);
      exp_wren  = (qa.size() > 0) && fb_grant;
      check_output("rnd_ready", 32'(ready), 32'(exp_ready));
      check_output("rnd_wren", 32'(fb_wren), 32'(exp_wren));
      check_output("rnd_idle", 32'(idle), 32'(qa.size() == 0));
      check_output("rnd_overflow", 32'(overflow), 32'(exp_ovf));
      check_output("rnd_clip", 32'(clip_count), 32'(exp_clip));
      if (qa.size() > 0) begin
        check_output("rnd_addr", 32'(fb_address), 32'(qa[0]));
        check_output("rnd_data", 32'(fb_data), 32'(qd[0]));
      end
      if (exp_wren) begin
        void'(qa.pop_front()); void'(qd.pop_front());
      end
      if (plot) begin
        if (!exp_ready) exp_ovf = 1'b1;
        else if (int'(x) < W && int'(y) < H) begin
          qa.push_back(int'(y) * W + int'(x));
          qd.push_back(int'(color));
        end else exp_clip = (exp_clip + 1) % 256;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
